// File: rtl/note_envelope.sv
// ---------------------------------------------------------------------------
// note_envelope
//
// ADSR amplitude envelope. It sits between note_player and the codec
// interface. An 8-bit gain steps once per beat (1/48 s) through
// ATTACK -> DECAY -> SUSTAIN, and moves to RELEASE on the rising edge of
// note_done. Every incoming sample is scaled by the current gain, so note
// boundaries fade in and out and do not click.
//
// Optional build macro: NOTE_ENVELOPE_EXP_RELEASE_EN
//   When defined, each RELEASE beat subtracts (gain>>3)+1 and RELEASE_STEP is
//   unused. When undefined, RELEASE is linear and subtracts RELEASE_STEP.
//
// Ports:
//   clk_i              system clock
//   reset_i            synchronous, active-low reset
//   play_enable_i      1 = envelope advances on beat, 0 = envelope frozen
//   note_start_i       one-cycle pulse, a new note was loaded
//   note_done_i        level, high once the current note has expired
//   beat_i             one-cycle 1/48 s tick
//   sample_in_i        signed 16-bit input sample
//   sample_in_valid_i  one-cycle qualifier for sample_in_i
//   sample_out_o       signed 16-bit enveloped sample (held between valids)
//   sample_out_valid_o one-cycle qualifier for sample_out_o
//   env_level_o        current gain, unsigned
//   env_state_o        IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
// ---------------------------------------------------------------------------
module note_envelope #(
    parameter int ATTACK_STEP   = 32,
    parameter int DECAY_STEP    = 8,
    parameter int SUSTAIN_LEVEL = 192,
    parameter int RELEASE_STEP  = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        play_enable_i,
    input  logic        note_start_i,
    input  logic        note_done_i,
    input  logic        beat_i,
    input  logic [15:0] sample_in_i,
    input  logic        sample_in_valid_i,
    output logic [15:0] sample_out_o,
    output logic        sample_out_valid_o,
    output logic [7:0]  env_level_o,
    output logic [2:0]  env_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  gain_q, gain_d;
    logic        note_done_q;
    logic [15:0] sample_out_q;
    logic        sample_out_valid_q;

    logic        done_rise;
    logic [8:0]  gain_ext;
    logic [8:0]  attack_sum;
    logic signed [8:0] decay_diff;
    logic [8:0]  release_dec;
    logic [8:0]  release_diff;
    logic signed [24:0] sample_ext;
    logic signed [24:0] gain_mult;
    logic signed [24:0] product;
    logic        unused_bits;

    // Only a fresh rise of note_done starts a release; a level left high
    // from the previous note must not kill the next one.
    assign done_rise = note_done_i & ~note_done_q;

    // All envelope arithmetic is carried in 9 bits so overflow past 255 and
    // underflow below 0 are visible to the saturation compares.
    assign gain_ext   = {1'b0, gain_q};
    assign attack_sum = gain_ext + 9'(ATTACK_STEP);
    assign decay_diff = $signed(gain_ext) - $signed(9'(DECAY_STEP));

`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
    // Exponential fade: the step shrinks with the gain, +1 guarantees the
    // envelope always reaches zero.
    assign release_dec = {4'b0000, gain_q[7:3]} + 9'd1;
`else
    assign release_dec = 9'(RELEASE_STEP);
`endif
    assign release_diff = gain_ext - release_dec;

    // Gain is zero-extended so it is treated as a positive multiplier.
    // The largest magnitude result (-32768*255) fits in 24 bits, so bit 24
    // is only a sign copy and bits 23:8 are the floored >>>8 result.
    assign sample_ext = {{9{sample_in_i[15]}}, sample_in_i};
    assign gain_mult  = {17'd0, gain_q};
    assign product    = sample_ext * gain_mult;

    assign unused_bits = ^{product[24], product[7:0], release_diff[8]};

    // Next-state decision. Priority is note_start, then a release-triggering
    // done edge, then the beat. note_start is taken even while paused and
    // keeps the current gain so a retriggered note glides instead of jumping.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (note_start_i) begin
            state_d = ATTACK;
        end else if (done_rise && (state_q == ATTACK || state_q == DECAY ||
                                   state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (beat_i && play_enable_i) begin
            case (state_q)
                ATTACK: begin
                    if (attack_sum >= 9'd255) begin
                        gain_d  = 8'd255;
                        state_d = DECAY;
                    end else begin
                        gain_d = attack_sum[7:0];
                    end
                end
                DECAY: begin
                    if (decay_diff <= $signed({1'b0, 8'(SUSTAIN_LEVEL)})) begin
                        gain_d  = 8'(SUSTAIN_LEVEL);
                        state_d = SUSTAIN;
                    end else begin
                        gain_d = decay_diff[7:0];
                    end
                end
                RELEASE: begin
                    if (gain_ext <= release_dec) begin
                        gain_d  = 8'd0;
                        state_d = IDLE;
                    end else begin
                        gain_d = release_diff[7:0];
                    end
                end
                default: begin
                    gain_d  = gain_q;
                    state_d = state_q;
                end
            endcase
        end
    end

    // Envelope state, done-edge history and the one-cycle sample pipeline.
    // Reset wins over everything, including a sample arriving that cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q            <= IDLE;
            gain_q             <= 8'd0;
            note_done_q        <= 1'b0;
            sample_out_q       <= 16'd0;
            sample_out_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            gain_q             <= gain_d;
            note_done_q        <= note_done_i;
            sample_out_valid_q <= sample_in_valid_i;
            if (sample_in_valid_i) begin
                sample_out_q <= product[23:8];
            end
        end
    end

    assign sample_out_o       = sample_out_q;
    assign sample_out_valid_o = sample_out_valid_q;
    assign env_level_o        = gain_q;
    assign env_state_o        = state_q;

endmodule

// File: tb/tb_note_envelope.sv
// ---------------------------------------------------------------------------
// tb_note_envelope
//
// Directed testbench for note_envelope. Each task drives one scenario and
// compares the envelope and sample outputs against hand-computed values.
// Honours NOTE_ENVELOPE_EXP_RELEASE_EN for the release-shape expectations.
// ---------------------------------------------------------------------------
module tb_note_envelope;

    logic        clk;
    logic        reset;
    logic        play_enable;
    logic        note_start;
    logic        note_done;
    logic        beat;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic [7:0]  env_level;
    logic [2:0]  env_state;

    int check_count = 0;
    int pass_count  = 0;

    note_envelope dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .play_enable_i      (play_enable),
        .note_start_i       (note_start),
        .note_done_i        (note_done),
        .beat_i             (beat),
        .sample_in_i        (sample_in),
        .sample_in_valid_i  (sample_in_valid),
        .sample_out_o       (sample_out),
        .sample_out_valid_o (sample_out_valid),
        .env_level_o        (env_level),
        .env_state_o        (env_state)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        sample_in       = 16'h4000;
        sample_in_valid = 1'b1;
        tick();
        tick();
        sample_in_valid = 1'b0;
        check_count++;
        if (env_state !== 3'd0) $display("[TB] FAIL reset_state: got %0d expected 0", env_state);
        else pass_count++;
        check_count++;
        if (env_level !== 8'd0) $display("[TB] FAIL reset_gain: got %0d expected 0", env_level);
        else pass_count++;
        check_count++;
        if (sample_out !== 16'h0000) $display("[TB] FAIL reset_out: got %h expected 0000", sample_out);
        else pass_count++;
        check_count++;
        if (sample_out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", sample_out_valid);
        else pass_count++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_attack();
        logic [7:0] exp_gain;
        note_start = 1'b1;
        tick();
        note_start = 1'b0;
        check_count++;
        if (env_state !== 3'd1 || env_level !== 8'd0)
            $display("[TB] FAIL attack_entry: state=%0d gain=%0d expected state=1 gain=0", env_state, env_level);
        else pass_count++;
        for (int i = 1; i <= 8; i++) begin
            pulse_beat();
            exp_gain = (i < 8) ? 8'(32 * i) : 8'd255;
            check_count++;
            if (env_level !== exp_gain)
                $display("[TB] FAIL attack_beat%0d: got %0d expected %0d", i, env_level, exp_gain);
            else pass_count++;
        end
        check_count++;
        if (env_state !== 3'd2) $display("[TB] FAIL attack_to_decay: got %0d expected 2", env_state);
        else pass_count++;
    endtask

    task automatic test_full_gain();
        sample_in       = 16'h7FFF;
        sample_in_valid = 1'b1;
        tick();
        check_count++;
        if (sample_out !== 16'h7F7F || sample_out_valid !== 1'b1)
            $display("[TB] FAIL full_gain_pos: got %h v=%b expected 7f7f v=1", sample_out, sample_out_valid);
        else pass_count++;
        sample_in = 16'h8000;
        tick();
        sample_in_valid = 1'b0;
        check_count++;
        if (sample_out !== 16'h8080 || sample_out_valid !== 1'b1)
            $display("[TB] FAIL full_gain_neg: got %h v=%b expected 8080 v=1", sample_out, sample_out_valid);
        else pass_count++;
        tick();
        check_count++;
        if (sample_out !== 16'h8080 || sample_out_valid !== 1'b0)
            $display("[TB] FAIL full_gain_hold: got %h v=%b expected 8080 v=0", sample_out, sample_out_valid);
        else pass_count++;
    endtask

    task automatic test_decay();
        int g = 255;
        for (int i = 1; i <= 8; i++) begin
            g = (g - 8 <= 192) ? 192 : g - 8;
            pulse_beat();
            check_count++;
            if (env_level !== 8'(g))
                $display("[TB] FAIL decay_beat%0d: got %0d expected %0d", i, env_level, g);
            else pass_count++;
        end
        check_count++;
        if (env_state !== 3'd3) $display("[TB] FAIL decay_to_sustain: got %0d expected 3", env_state);
        else pass_count++;
        pulse_beat();
        check_count++;
        if (env_level !== 8'd192 || env_state !== 3'd3)
            $display("[TB] FAIL sustain_hold: gain=%0d state=%0d expected 192/3", env_level, env_state);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        sample_in       = 16'h4000;
        sample_in_valid = 1'b1;
        tick();
        check_count++;
        if (sample_out !== 16'h3000 || sample_out_valid !== 1'b1)
            $display("[TB] FAIL b2b_first: got %h v=%b expected 3000 v=1", sample_out, sample_out_valid);
        else pass_count++;
        sample_in = 16'hC000;
        tick();
        sample_in_valid = 1'b0;
        check_count++;
        if (sample_out !== 16'hD000 || sample_out_valid !== 1'b1)
            $display("[TB] FAIL b2b_second: got %h v=%b expected d000 v=1", sample_out, sample_out_valid);
        else pass_count++;
        tick();
        check_count++;
        if (sample_out !== 16'hD000 || sample_out_valid !== 1'b0)
            $display("[TB] FAIL b2b_hold: got %h v=%b expected d000 v=0", sample_out, sample_out_valid);
        else pass_count++;
    endtask

    task automatic test_release();
        int g = 192;
        int beats = 0;
        note_done = 1'b1;
        tick();
        check_count++;
        if (env_state !== 3'd4 || env_level !== 8'd192)
            $display("[TB] FAIL release_entry: state=%0d gain=%0d expected 4/192", env_state, env_level);
        else pass_count++;
        while (g != 0 && beats < 64) begin
`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
            g = (g <= (g >> 3) + 1) ? 0 : g - ((g >> 3) + 1);
`else
            g = (g <= 16) ? 0 : g - 16;
`endif
            pulse_beat();
            beats++;
            check_count++;
            if (env_level !== 8'(g))
                $display("[TB] FAIL release_beat%0d: got %0d expected %0d", beats, env_level, g);
            else pass_count++;
        end
`ifndef NOTE_ENVELOPE_EXP_RELEASE_EN
        check_count++;
        if (beats != 12) $display("[TB] FAIL release_length: got %0d beats expected 12", beats);
        else pass_count++;
`endif
        check_count++;
        if (env_state !== 3'd0) $display("[TB] FAIL release_to_idle: got %0d expected 0", env_state);
        else pass_count++;
    endtask

    task automatic test_done_level();
        // note_done is still high from the previous note
        note_start = 1'b1;
        tick();
        note_start = 1'b0;
        tick();
        tick();
        pulse_beat();
        check_count++;
        if (env_state !== 3'd1 || env_level !== 8'd32)
            $display("[TB] FAIL done_level_ignored: state=%0d gain=%0d expected 1/32", env_state, env_level);
        else pass_count++;
    endtask

    task automatic test_start_beat();
        note_start = 1'b1;
        beat       = 1'b1;
        tick();
        note_start = 1'b0;
        beat       = 1'b0;
        check_count++;
        if (env_state !== 3'd1 || env_level !== 8'd32)
            $display("[TB] FAIL start_with_beat: state=%0d gain=%0d expected 1/32", env_state, env_level);
        else pass_count++;
    endtask

    task automatic test_freeze();
        play_enable = 1'b0;
        for (int i = 0; i < 3; i++) pulse_beat();
        check_count++;
        if (env_state !== 3'd1 || env_level !== 8'd32)
            $display("[TB] FAIL freeze: state=%0d gain=%0d expected 1/32", env_state, env_level);
        else pass_count++;
        sample_in       = 16'h4000;
        sample_in_valid = 1'b1;
        tick();
        sample_in_valid = 1'b0;
        check_count++;
        if (sample_out !== 16'h0800 || sample_out_valid !== 1'b1)
            $display("[TB] FAIL freeze_sample: got %h v=%b expected 0800 v=1", sample_out, sample_out_valid);
        else pass_count++;
        play_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_gain;
        note_done = 1'b0;
        tick();
        note_done = 1'b1;
        tick();
        check_count++;
        if (env_state !== 3'd4 || env_level !== 8'd32)
            $display("[TB] FAIL mid_release_entry: state=%0d gain=%0d expected 4/32", env_state, env_level);
        else pass_count++;
        pulse_beat();
`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
        exp_gain = 8'd27;
`else
        exp_gain = 8'd16;
`endif
        check_count++;
        if (env_level !== exp_gain)
            $display("[TB] FAIL mid_release_beat: got %0d expected %0d", env_level, exp_gain);
        else pass_count++;
        reset           = 1'b0;
        sample_in       = 16'h4000;
        sample_in_valid = 1'b1;
        tick();
        reset           = 1'b1;
        sample_in_valid = 1'b0;
        check_count++;
        if (env_state !== 3'd0 || env_level !== 8'd0)
            $display("[TB] FAIL mid_reset_env: state=%0d gain=%0d expected 0/0", env_state, env_level);
        else pass_count++;
        check_count++;
        if (sample_out !== 16'h0000 || sample_out_valid !== 1'b0)
            $display("[TB] FAIL mid_reset_out: got %h v=%b expected 0000 v=0", sample_out, sample_out_valid);
        else pass_count++;
    endtask

    initial begin
        reset           = 1'b0;
        play_enable     = 1'b1;
        note_start      = 1'b0;
        note_done       = 1'b0;
        beat            = 1'b0;
        sample_in       = 16'h0000;
        sample_in_valid = 1'b0;
        #2;
        test_reset();
        test_attack();
        test_full_gain();
        test_decay();
        test_back_to_back();
        test_release();
        test_done_level();
        test_start_beat();
        test_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
